// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: Avalon-MM read master that fetches sysid words 0/1 and checks them against expected values.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID       = 32'd0,
  parameter logic [31:0] EXPECTED_TS       = 32'd1480546884,
  parameter bit          USE_READDATAVALID = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
  logic        id_match_q, id_match_d, ts_match_q, ts_match_d, timeout_q, timeout_d;
  logic        id_hit_q, id_hit_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic        in_req, in_wait, is_ts, accept, cap, expire, retry, launch;
  assign in_req  = state_q == ID_REQ || state_q == TS_REQ;
  assign in_wait = state_q == ID_WAIT || state_q == TS_WAIT;
  assign is_ts   = state_q == TS_REQ || state_q == TS_WAIT;
  assign accept  = read_q & ~avm_waitrequest;
  assign cap     = in_req ? (accept && !USE_READDATAVALID) : (in_wait && avm_readdatavalid);
  // a capture on the final counted cycle beats the timeout
  assign expire  = (in_req || in_wait) && !cap && cnt_q == CNT_LAST;
  assign retry   = expire && retry_q < RETRY_MAX;
  assign launch  = (state_q == IDLE || state_q == DONE) && start;
  always_comb begin
    state_d    = state_q;
    cnt_d      = (in_req || in_wait) ? cnt_q + 16'd1 : cnt_q;
    retry_d    = retry_q;
    done_d     = done_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    id_hit_d   = id_hit_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    if (launch) begin
      state_d    = ID_REQ;
      cnt_d      = '0;
      retry_d    = '0;
      done_d     = 1'b0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
      timeout_d  = 1'b0;
      id_hit_d   = 1'b0;
      id_value_d = '0;
      ts_value_d = '0;
    end else if (cap) begin
      state_d    = is_ts ? DONE : TS_REQ;
      ts_value_d = is_ts ? avm_readdata : ts_value_q;
      id_value_d = is_ts ? id_value_q : avm_readdata;
      id_hit_d   = is_ts ? id_hit_q : avm_readdata == EXPECTED_ID;
      cnt_d      = is_ts ? cnt_d : '0;
      retry_d    = is_ts ? retry_q : '0;
    end else if (retry) begin
      state_d = is_ts ? TS_REQ : ID_REQ;
      cnt_d   = '0;
      retry_d = retry_q + 4'd1;
    end else if (expire) begin
      state_d   = DONE;
      timeout_d = 1'b1;
    end else if (in_req && accept) begin
      state_d = is_ts ? TS_WAIT : ID_WAIT;
    end
    if (state_d == DONE && state_q != DONE) begin
      done_d     = 1'b1;
      id_match_d = id_hit_d;
      ts_match_d = cap && is_ts && avm_readdata == EXPECTED_TS;
    end
    // a retry re-enters *_REQ with read low for one cycle to separate attempts
    read_d = (state_d == ID_REQ || state_d == TS_REQ) && !retry;
    addr_d = state_d == TS_REQ || state_d == TS_WAIT;
    busy_d = state_d != IDLE && state_d != DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_hit_q   <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_hit_q   <= id_hit_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end
  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb_nios_system_sysid_checker: two checker instances (sample-on-accept and readdatavalid) against a scripted sysid slave.
module tb_nios_system_sysid_checker;
  localparam logic [31:0] TS_VAL = 32'd1480546884;
  logic clk;
  logic rst[2], start[2], rd[2], addr[2], wr[2], rdv[2];
  logic busy[2], done[2], idm[2], tsm[2], to[2];
  logic [31:0] rdata[2], idv[2], tsv[2];
  int checks = 0, failures = 0, cyc = 0, rel;
  int waits[2], rdly[2], scnt[2], cd[2];
  logic [31:0] mem0[2], mem1[2], pend[2];
  bit armed[2], prev_rd[2], found;
  int s_edge[2], e_d[2], e_att[2], e_rdc[2], att[2], rdc[2], done_rel[2];
  logic e_idm[2], e_tsm[2], e_to[2];
  logic [31:0] e_idv[2], e_tsv[2];

  nios_system_sysid_checker #(.USE_READDATAVALID(1'b0), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) dut_a (
    .clock(clk), .reset(rst[0]), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
    .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
    .busy(busy[0]), .done(done[0]), .id_match(idm[0]), .ts_match(tsm[0]), .timeout(to[0]),
    .id_value(idv[0]), .ts_value(tsv[0]));
  nios_system_sysid_checker #(.USE_READDATAVALID(1'b1), .TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut_b (
    .clock(clk), .reset(rst[1]), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
    .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
    .busy(busy[1]), .done(done[1]), .id_match(idm[1]), .ts_match(tsm[1]), .timeout(to[1]),
    .id_value(idv[1]), .ts_value(tsv[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // slave: stalls `waits` cycles per read, answers addr0/addr1 from mem0/mem1, readdatavalid `rdly` cycles after accept
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rdv[k] = 1'b0;
      rdata[k] = 32'h0BAD_0BAD;
      wr[k] = 1'b0;
      if (rst[k]) begin
        scnt[k] = 0;
        cd[k] = 0;
      end else begin
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) begin
            rdv[k] = 1'b1;
            rdata[k] = pend[k];
          end
        end
        if (rd[k]) begin
          if (scnt[k] < waits[k]) begin
            wr[k] = 1'b1;
            scnt[k]++;
          end else begin
            scnt[k] = 0;
            pend[k] = addr[k] ? mem1[k] : mem0[k];
            cd[k] = rdly[k];
            if (rdly[k] == 0) rdata[k] = pend[k];
          end
        end
      end
    end
  end

  // per-cycle comparison against the transaction-level expectation of the current run
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        rel = cyc - s_edge[k];
        if (rel < e_d[k]) begin
          chk(k, "busy_run", busy[k], 1);
          chk(k, "done_run", done[k], 0);
          chk(k, "timeout_run", to[k], 0);
          chk(k, "id_match_run", idm[k], 0);
          chk(k, "ts_match_run", tsm[k], 0);
          if (rel == 0) begin
            chk(k, "id_value_clr", idv[k], 0);
            chk(k, "ts_value_clr", tsv[k], 0);
          end
          if (rd[k] && !prev_rd[k]) att[k]++;
          if (rd[k]) rdc[k]++;
        end else begin
          if (rel == e_d[k]) begin
            chk(k, "read_attempts", att[k], e_att[k]);
            chk(k, "read_cycles", rdc[k], e_rdc[k]);
          end
          chk(k, "busy_done", busy[k], 0);
          chk(k, "done_done", done[k], 1);
          chk(k, "id_match", idm[k], e_idm[k]);
          chk(k, "ts_match", tsm[k], e_tsm[k]);
          chk(k, "timeout", to[k], e_to[k]);
          chk(k, "id_value", idv[k], e_idv[k]);
          chk(k, "ts_value", tsv[k], e_tsv[k]);
          chk(k, "read_idle", rd[k], 0);
        end
        if (done[k] && done_rel[k] < 0) done_rel[k] = rel;
      end
      prev_rd[k] = rd[k];
    end
  end

  // expected finish time/flags from slave timing: each word costs 1+w+d cycles, a dead slave costs (R+1)*T
  task automatic launch(input int k, input int w, input int d, input bit stuck, input logic [31:0] m0, input logic [31:0] m1);
    int t, r;
    t = k ? 16 : 8;
    r = k ? 3 : 2;
    @(negedge clk);
    mem0[k] = m0;
    mem1[k] = m1;
    waits[k] = stuck ? 100000 : w;
    rdly[k] = d;
    e_d[k] = stuck ? (r + 1) * t : 2 * (1 + w + d);
    e_rdc[k] = stuck ? t + r * (t - 1) : 2 * (w + 1);
    e_att[k] = stuck ? r + 1 : (k ? 2 : 1);
    e_to[k] = stuck;
    e_idv[k] = stuck ? 32'd0 : m0;
    e_tsv[k] = stuck ? 32'd0 : m1;
    e_idm[k] = !stuck && m0 == 32'd0;
    e_tsm[k] = !stuck && m1 == TS_VAL;
    s_edge[k] = cyc + 1;
    att[k] = 0;
    rdc[k] = 0;
    done_rel[k] = -1;
    armed[k] = 1'b1;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic settle(input int k);
    repeat (e_d[k] + 3) @(negedge clk);
  endtask

  task automatic chk_zero(input int k);
    chk(k, "rst_busy", busy[k], 0);
    chk(k, "rst_done", done[k], 0);
    chk(k, "rst_id_match", idm[k], 0);
    chk(k, "rst_ts_match", tsm[k], 0);
    chk(k, "rst_timeout", to[k], 0);
    chk(k, "rst_id_value", idv[k], 0);
    chk(k, "rst_ts_value", tsv[k], 0);
    chk(k, "rst_read", rd[k], 0);
    chk(k, "rst_address", addr[k], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      start[k] = 1'b0;
      waits[k] = 0;
      rdly[k] = 0;
      armed[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    // zero-wait, sample on accept
    launch(0, 0, 0, 0, 32'd0, TS_VAL);
    settle(0);
    chk(0, "t1_done_latency", done_rel[0], 2);
    chk(0, "t1_read_cycles_lit", rdc[0], 2);
    chk(0, "t1_ts_value_lit", tsv[0], 32'h583F_5A44);
    // bad timestamp
    launch(0, 0, 0, 0, 32'd0, 32'hDEAD_BEEF);
    settle(0);
    chk(0, "t3_ts_match_lit", tsm[0], 0);
    chk(0, "t3_id_match_lit", idm[0], 1);
    // accept lands on the last counted cycle
    launch(0, 7, 0, 0, 32'd0, TS_VAL);
    settle(0);
    // waitrequest stuck: three attempts then timeout
    launch(0, 0, 0, 1, 32'd0, TS_VAL);
    settle(0);
    chk(0, "t4_done_latency", done_rel[0], 24);
    chk(0, "t4_attempts_lit", att[0], 3);
    chk(0, "t4_timeout_lit", to[0], 1);
    chk(0, "t4_id_match_lit", idm[0], 0);
    // stalled slave with readdatavalid latency
    launch(1, 4, 2, 0, 32'd0, TS_VAL);
    settle(1);
    chk(1, "t2_done_latency", done_rel[1], 14);
    chk(1, "t2_matches_lit", {idm[1], tsm[1]}, 2'b11);
    // capture on the same cycle the timeout would fire
    launch(1, 5, 10, 0, 32'd0, TS_VAL);
    settle(1);
    chk(1, "tb_boundary_timeout_lit", to[1], 0);
    // start while busy is ignored; start in DONE reruns with cleared flags
    launch(1, 1, 1, 0, 32'd0, TS_VAL);
    repeat (2) begin
      @(negedge clk) start[1] = 1'b1;
      @(negedge clk) start[1] = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk(1, "t6_first_done_latency", done_rel[1], 6);
    launch(1, 1, 1, 0, 32'd0, 32'hDEAD_BEEF);
    settle(1);
    chk(1, "t6_rerun_ts_match_lit", tsm[1], 0);
    // reset in TS_WAIT
    launch(1, 2, 10, 0, 32'd0, TS_VAL);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (addr[1] && !rd[1] && busy[1]) begin
        found = 1'b1;
        break;
      end
    end
    chk(1, "t5_reach_ts_wait", found, 1);
    armed[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    chk_zero(1);
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);
    launch(1, 0, 1, 0, 32'd0, TS_VAL);
    settle(1);
    chk(1, "t5_after_reset_lit", {done[1], idm[1], tsm[1], to[1]}, 4'b1110);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
